sram_responder: RTL and testbench

//  Synchronous SRAM device model: the responder end of the active-low cs/we/oe strobe interface driven by sram_controller.

---
 rtl/sram_responder.sv | 152 +++++++++++++++
 tb/tb_sram_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// Synchronous SRAM responder: strobe decode, array, timed read return.
// Optional stored-parity checking when SRAM_PARITY_EN is defined.
module sram_responder #(
   parameter int ADDR_WIDTH   = 16,
   parameter int DATA_WIDTH   = 8,
   parameter int MEM_DEPTH    = 1024,
   parameter int READ_LATENCY = 1,
   parameter int DRIVE_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  sram_cs,
   input  logic                  sram_we,
   input  logic                  sram_oe,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_drive,
   output logic                  rd_valid,
   output logic                  busy,
   output logic                  err,
   output logic [7:0]            viol_count,
   output logic                  parity_err
);

`ifdef SRAM_PARITY_EN
   localparam int MW = DATA_WIDTH + 1;
`else
   localparam int MW = DATA_WIDTH;
`endif
   localparam int IW = $clog2(MEM_DEPTH);
   localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      RD_DRIVE
   } state_t;

   logic [MW-1:0]         mem [MEM_DEPTH];
   state_t                state;
   logic [1:0]            cnt;
   logic [DATA_WIDTH-1:0] cap_data;

   logic          in_range;
   logic [IW-1:0] idx;
   logic          wr;
   logic          rd;
   logic          err_ev;
   logic [MW-1:0] wr_word;
   logic [MW-1:0] rd_word;
   logic          perr_now;

`ifdef SRAM_PARITY_EN
   logic cap_perr;
`endif

   // Access decode and error source merge for the current edge
   always_comb begin
      in_range = {1'b0, address} < DEPTH;
      idx      = address[IW-1:0];
      wr       = !sram_cs && !sram_we;
      rd       = !sram_cs && sram_we && !sram_oe;
      rd_word  = mem[idx];
`ifdef SRAM_PARITY_EN
      wr_word  = {^data_in, data_in};
      perr_now = (state == RD_WAIT) && (cnt == 2'd0) && cap_perr;
`else
      wr_word  = data_in;
      perr_now = 1'b0;
`endif
      err_ev   = (wr && !sram_oe)
               || (rd && busy)
               || ((wr || rd) && !in_range)
               || perr_now;
   end

   // Array write port; contents intentionally survive reset
   always_ff @(posedge clk) begin
      if (wr && in_range)
         mem[idx] <= wr_word;
   end

   // Read FSM with registered outputs and violation counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         cnt        <= 2'd0;
         cap_data   <= '0;
         data_out   <= '0;
         data_drive <= 1'b0;
         rd_valid   <= 1'b0;
         busy       <= 1'b0;
         err        <= 1'b0;
         viol_count <= 8'd0;
`ifdef SRAM_PARITY_EN
         cap_perr   <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         rd_valid <= 1'b0;
         err      <= err_ev;
`ifdef SRAM_PARITY_EN
         parity_err <= 1'b0;
`endif
         if (err_ev && viol_count != 8'hFF)
            viol_count <= viol_count + 8'd1;
         unique case (state)
            IDLE: begin
               if (rd) begin
                  state    <= RD_WAIT;
                  busy     <= 1'b1;
                  cnt      <= 2'(READ_LATENCY - 1);
                  cap_data <= in_range ? rd_word[DATA_WIDTH-1:0] : '1;
`ifdef SRAM_PARITY_EN
                  cap_perr <= in_range && (^rd_word);
`endif
               end
            end
            RD_WAIT: begin
               if (cnt == 2'd0) begin
                  state      <= RD_DRIVE;
                  data_drive <= 1'b1;
                  rd_valid   <= 1'b1;
                  data_out   <= cap_data;
                  cnt        <= 2'(DRIVE_CYCLES - 1);
`ifdef SRAM_PARITY_EN
                  parity_err <= cap_perr;
`endif
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            RD_DRIVE: begin
               if (cnt == 2'd0) begin
                  state      <= IDLE;
                  data_drive <= 1'b0;
                  busy       <= 1'b0;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef SRAM_PARITY_EN
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: directed steps plus random traffic
// against a timeline model of read windows and violations.
module tb_sram_responder;

   localparam int L = 2;
   localparam int D = 2;

   logic        clk;
   logic        reset_n;
   logic        sram_cs;
   logic        sram_we;
   logic        sram_oe;
   logic [15:0] address;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic        data_drive;
   logic        rd_valid;
   logic        busy;
   logic        err;
   logic [7:0]  viol_count;
   logic        parity_err;

   sram_responder #(
      .ADDR_WIDTH(16),
      .DATA_WIDTH(8),
      .MEM_DEPTH(1024),
      .READ_LATENCY(L),
      .DRIVE_CYCLES(D)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .sram_cs(sram_cs),
      .sram_we(sram_we),
      .sram_oe(sram_oe),
      .address(address),
      .data_in(data_in),
      .data_out(data_out),
      .data_drive(data_drive),
      .rd_valid(rd_valid),
      .busy(busy),
      .err(err),
      .viol_count(viol_count),
      .parity_err(parity_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // model: one read timeline, sticky output, counter, word map
   int         n = 0;
   int         rd_t = -100;
   logic [7:0] rd_v = 8'h00;
   bit         rd_p = 0;
   bit         corrupt = 0;
   logic [7:0] last_out = 8'h00;
   int         viol = 0;
   bit         err_e = 0;
   logic [7:0] mm [int];

   function automatic bit m_busy(int m);
      return rd_t >= 0 && m >= rd_t && m < rd_t + L + D;
   endfunction

   function automatic bit m_drive(int m);
      return rd_t >= 0 && m >= rd_t + L && m < rd_t + L + D;
   endfunction

   task automatic chk(input string tag,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, act, exp);
      end
   endtask

   task automatic chk_all();
      chk("data_drive", 32'(data_drive), 32'(m_drive(n)));
      chk("rd_valid", 32'(rd_valid),
          32'(rd_t >= 0 && n == rd_t + L));
      chk("busy", 32'(busy), 32'(m_busy(n)));
      chk("err", 32'(err), 32'(err_e));
      chk("viol_count", 32'(viol_count), 32'(viol));
      chk("data_out", 32'(data_out), 32'(last_out));
      chk("parity_err", 32'(parity_err),
          32'(rd_t >= 0 && n == rd_t + L && rd_p));
   endtask

   task automatic model_reset();
      rd_t = -100;
      rd_p = 0;
      last_out = 8'h00;
      viol = 0;
      err_e = 0;
   endtask

   task automatic step(input logic cs, input logic we,
                       input logic oe, input logic [15:0] a,
                       input logic [7:0] d);
      bit ev;
      bit bz;
      bit inr;
      sram_cs = cs;
      sram_we = we;
      sram_oe = oe;
      address = a;
      data_in = d;
      @(posedge clk);
      bz = m_busy(n);
      n++;
      ev = 0;
      inr = int'(a) < 1024;
      if (!cs) begin
         if (!we) begin
            if (inr) mm[int'(a)] = d;
            else ev = 1;
            if (!oe) ev = 1;
         end else if (!oe) begin
            if (!inr) ev = 1;
            if (bz) ev = 1;
            else begin
               rd_t = n;
               rd_v = inr ? mm[int'(a)] : 8'hFF;
               rd_p = inr && corrupt;
               corrupt = 0;
            end
         end
      end
      if (rd_t >= 0 && n == rd_t + L && rd_p) ev = 1;
      err_e = ev;
      if (ev && viol < 255) viol++;
      if (m_drive(n)) last_out = rd_v;
      #1;
      chk_all();
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++)
         step(1, 1, 1, 16'h0, 8'h0);
   endtask

   initial begin
      reset_n = 1'b0;
      sram_cs = 1'b1;
      sram_we = 1'b1;
      sram_oe = 1'b1;
      address = 16'h0;
      data_in = 8'h0;
      #2;
      chk_all();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      idle(1);

      // write A5 then read it back
      step(0, 0, 1, 16'h0010, 8'hA5);
      step(0, 1, 0, 16'h0010, 8'h00);
      idle(5);

      // read, then overwrite the same word while in flight
      step(0, 1, 0, 16'h0010, 8'h00);
      step(0, 0, 1, 16'h0010, 8'h3C);
      idle(4);
      step(0, 1, 0, 16'h0010, 8'h00);
      idle(5);

      // we+oe clash still writes; second read while busy dropped
      step(0, 0, 0, 16'h0020, 8'h77);
      step(0, 1, 0, 16'h0020, 8'h00);
      step(0, 1, 0, 16'h0010, 8'h00);
      idle(4);
      step(0, 1, 1, 16'h0020, 8'h00);
      idle(1);

      // reset in the middle of the drive window
      step(0, 1, 0, 16'h0020, 8'h00);
      idle(2);
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      chk_all();
      #2;
      reset_n = 1'b1;
      idle(5);

      // random traffic over a preloaded pool
      for (int i = 0; i < 16; i++)
         step(0, 0, 1, 16'h0100 + 16'(i), 8'($urandom));
      for (int i = 0; i < 400; i++) begin
         int op;
         logic [15:0] pa;
         op = int'($urandom_range(0, 9));
         pa = 16'h0100 + 16'($urandom_range(0, 15));
         case (op)
            0, 1: step(1, 1, 1, 16'($urandom), 8'($urandom));
            2, 3: step(0, 0, 1, pa, 8'($urandom));
            4, 5, 6: step(0, 1, 0, pa, 8'($urandom));
            7: step(0, 0, 0, pa, 8'($urandom));
            8: step(0, 1, 1, pa, 8'($urandom));
            default:
               step(0, 1'($urandom), 1'($urandom),
                    16'(1024 + $urandom_range(0, 64511)),
                    8'($urandom));
         endcase
      end
      idle(6);

`ifdef SRAM_PARITY_EN
      // corrupt stored parity and read the word back
      step(0, 0, 1, 16'h0030, 8'h01);
      dut.mem[10'h030][8] = ~dut.mem[10'h030][8];
      corrupt = 1;
      step(0, 1, 0, 16'h0030, 8'h00);
      idle(5);
`endif

      // out-of-range read returns all ones
      step(0, 1, 0, 16'h0400, 8'h00);
      idle(5);

      // saturate the violation counter
      for (int i = 0; i < 300; i++)
         step(0, 0, 1, 16'hFFFF, 8'h55);
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
